load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORDS, default 32, meaning the number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter IDX_W, default 5, meaning the memory word-index width, equal to clog2(WORDS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have req_valid in 1, req_ready out 1, req_write in 1, req_size in 2 (00 byte, 01 half, 10 word, 11 illegal), req_unsigned in 1, req_addr in 32 (byte address), req_wdata in 32.
REQ-006 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_err out 1.
REQ-007 SHALL have mem_addr out IDX_W, mem_wd out 32, mem_write out 1, mem_rd in 32, where mem_rd is the combinational read of word mem_addr.

Function
REQ-008 SHALL assert req_ready only in state IDLE; a request is accepted on a cycle with req_valid && req_ready, and all req_* fields are latched then.
REQ-009 SHALL use states IDLE, EXEC, MERGE_WR and RESP; accept moves IDLE->EXEC.
REQ-010 SHALL drive mem_addr = latched addr[IDX_W+1:2] in EXEC and MERGE_WR, and 0 otherwise.
REQ-011 SHALL flag an error in EXEC when size=11, or half with addr[0]=1, or word with addr[1:0]!=0, or addr >= 4*WORDS; it SHALL then make no memory access, set rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-012 Load in EXEC SHALL select the byte or half at addr[1:0] from mem_rd, sign-extend or zero-extend it per req_unsigned (word passes through), register it into rsp_rdata, and go to RESP.
REQ-013 Word store in EXEC SHALL assert mem_write=1 with mem_wd=wdata for exactly one cycle and go to RESP.
REQ-014 Byte or half store in EXEC SHALL register the merge of mem_rd with wdata[7:0] or wdata[15:0] at the byte lanes given by addr[1:0] and go to MERGE_WR.
REQ-015 MERGE_WR SHALL assert mem_write=1 with mem_wd=merged word for one cycle and go to RESP.
REQ-016 RESP SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then go to IDLE; for stores, rsp_rdata=0.
REQ-017 Latency from accept to first rsp_valid SHALL be 2 cycles for loads, word stores and errors, and 3 cycles for sub-word stores.
REQ-018 Back-to-back operation SHALL give a throughput of one request per 3 cycles (4 for sub-word stores) when rsp_ready is held at 1.
REQ-019 mem_write SHALL be 0 in IDLE and RESP, and SHALL never be asserted for an errored request.
REQ-020 req_valid arriving outside IDLE SHALL be ignored; the requester must hold it until accepted.

Reset
REQ-021 On reset=0 at a clock edge, the unit SHALL enter IDLE with req_ready=1 after the edge, rsp_valid=0, rsp_rdata=0, rsp_err=0 and mem_write=0.
REQ-022 Reset in any state, including MERGE_WR, SHALL abort the operation with no memory write in that cycle; the pending request is lost.

Structure
REQ-023 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum type.
REQ-024 A combinational sub-module lsu_align SHALL provide load extract/extend and store merge; all state SHALL live in load_store_unit.

Verification
REQ-025 Memory word 1 = 0x0000_0014; load word at addr 0x04 -> rsp_valid 2 cycles after accept, rsp_rdata=0x14, rsp_err=0.
REQ-026 Word 2 = 0x1234_80FF; signed byte load at 0x08 -> 0xFFFF_FFFF; unsigned half load at 0x0A -> 0x0000_1234; signed half load at 0x08 -> 0xFFFF_80FF.
REQ-027 Word 3 = 0xAABB_CCDD; byte store 0x11 at 0x0D -> one mem_write pulse in MERGE_WR, word 3 = 0xAABB_11DD, rsp_valid 3 cycles after accept.
REQ-028 Half load at 0x03, word store at 0x06, and any access at 0x80 -> rsp_err=1, rsp_rdata=0, mem_write never asserted.
REQ-029 Hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; release -> IDLE next cycle.
REQ-030 Assert reset=0 during MERGE_WR of a half store -> no write occurs, target word unchanged, outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: extracts and extends load data from a memory
// word, and merges sub-word store data into a memory word. Holds no state.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the memory word
    always_comb begin
        byte_sel = rd_word[7:0];
        case (offset)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Zero- or sign-extend the selected field; words pass through untouched
    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'd0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = is_unsigned ? {16'd0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Replace only the byte lanes the store covers, keep the rest of the word
    always_comb begin
        merged = rd_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: merged = {rd_word[31:8], wdata[7:0]};
                    2'd1: merged = {rd_word[31:16], wdata[7:0], rd_word[7:0]};
                    2'd2: merged = {rd_word[31:24], wdata[7:0], rd_word[15:0]};
                    2'd3: merged = {wdata[7:0], rd_word[23:0]};
                    default: merged = rd_word;
                endcase
            end
            SZ_HALF: merged = offset[1] ? {wdata[15:0], rd_word[15:0]}
                                        : {rd_word[31:16], wdata[15:0]};
            default: merged = rd_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time, performs it
// against a single-port word memory with combinational read, and returns a
// response. Sub-word stores are done as read-modify-write over two cycles.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both 1. The source holds valid and its payload stable until that edge; ready
// may be low for any number of cycles. Here req_ready is 1 only in IDLE, and
// rsp_valid stays high with a stable payload in RESP until rsp_ready is seen.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORDS = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    // data memory port
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wd,
    output logic             mem_write,
    input  logic [31:0]      mem_rd,
    // current FSM state, for observation only
    output lsu_state_t       dbg_state
);

    localparam logic [31:0] MEM_BYTES = 32'(WORDS * 4);

    lsu_state_t  state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;

    logic        access_err;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign dbg_state = state;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .offset      (addr_q[1:0]),
        .rd_word     (mem_rd),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Classify the latched request: illegal size, misalignment, or out of range
    always_comb begin
        access_err = 1'b0;
        case (size_q)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = addr_q[0];
            SZ_WORD: access_err = |addr_q[1:0];
            default: access_err = 1'b1;
        endcase
        if (addr_q >= MEM_BYTES) begin
            access_err = 1'b1;
        end
    end

    // Memory port drive; writes are suppressed while reset is low so an
    // aborted operation never reaches memory
    always_comb begin
        mem_addr  = '0;
        mem_wd    = '0;
        mem_write = 1'b0;
        if (state == EXEC || state == MERGE_WR) begin
            mem_addr = addr_q[IDX_W+1:2];
        end
        if (reset) begin
            if (state == EXEC && write_q && size_q == SZ_WORD && !access_err) begin
                mem_write = 1'b1;
                mem_wd    = wdata_q;
            end else if (state == MERGE_WR) begin
                mem_write = 1'b1;
                mem_wd    = merged_q;
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (access_err) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (!write_q) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        merged_q <= merged;
                        state    <= MERGE_WR;
                    end
                end
                MERGE_WR: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an attached 32-word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wd;
    logic        mem_write;
    logic [31:0] mem_rd;
    lsu_state_t  dbg_state;

    logic [31:0] mem [32];

    int n_tests;
    int n_fail;
    int write_cnt;
    int merge_wr_cnt;
    int accept_cnt;

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          nwr;

    load_store_unit #(.WORDS(32), .IDX_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_write    (mem_write),
        .mem_rd       (mem_rd),
        .dbg_state    (dbg_state)
    );

    // clock / memory / monitors
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wd;
    end

    always @(negedge clk) begin
        if (mem_write) write_cnt++;
        if (mem_write && dbg_state == MERGE_WR) merge_wr_cnt++;
        if (req_valid && req_ready) accept_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with rsp_ready held high; returns latency from accept
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int wb;
        int guard;
        wb = write_cnt;
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin tick(); guard++; end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
        tick();
        nwr = write_cnt - wb;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick(); tick();
        reset = 1'b1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_load_word();
        do_req(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_tests++; if (rd !== 32'h0000_0014) begin n_fail++; $display("FAIL lw_rdata got %h want 00000014", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b want 0", er); end
        n_tests++; if (nwr !== 0) begin n_fail++; $display("FAIL lw_writes got %0d want 0", nwr); end
    endtask

    task automatic test_load_sub();
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h08, 32'h0);
        n_tests++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb_08 got %h want ffffffff", rd); end
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0);
        n_tests++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_09 got %h want 00000080", rd); end
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0);
        n_tests++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_09 got %h want ffffff80", rd); end
        do_req(1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0);
        n_tests++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL lhu_0a got %h want 00001234", rd); end
        do_req(1'b0, SZ_HALF, 1'b0, 32'h08, 32'h0);
        n_tests++; if (rd !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_08 got %h want ffff80ff", rd); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lh_latency got %0d want 2", lat); end
    endtask

    task automatic test_store();
        int mb;
        mb = merge_wr_cnt;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h0D, 32'hFFFF_FF11);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d want 3", lat); end
        n_tests++; if (nwr !== 1) begin n_fail++; $display("FAIL sb_writes got %0d want 1", nwr); end
        n_tests++; if (merge_wr_cnt - mb !== 1) begin n_fail++; $display("FAIL sb_merge_writes got %0d want 1", merge_wr_cnt - mb); end
        n_tests++; if (mem[3] !== 32'hAABB_11DD) begin n_fail++; $display("FAIL sb_word3 got %h want aabb11dd", mem[3]); end
        n_tests++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sb_rsp got %h/%b want 0/0", rd, er); end
        do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h7777_BEEF);
        n_tests++; if (mem[4] !== 32'hBEEF_4567) begin n_fail++; $display("FAIL sh_word4 got %h want beef4567", mem[4]); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency got %0d want 3", lat); end
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFE_F00D);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_tests++; if (nwr !== 1) begin n_fail++; $display("FAIL sw_writes got %0d want 1", nwr); end
        n_tests++; if (mem[5] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_word5 got %h want cafef00d", mem[5]); end
    endtask

    task automatic test_errors();
        do_req(1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lh_03 got err=%b rdata=%h want 1/0", er, rd); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency got %0d want 2", lat); end
        do_req(1'b1, SZ_WORD, 1'b0, 32'h06, 32'hDEAD_BEEF);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_sw_06 got err=%b rdata=%h want 1/0", er, rd); end
        n_tests++; if (nwr !== 0) begin n_fail++; $display("FAIL err_sw_06_writes got %0d want 0", nwr); end
        n_tests++; if (mem[1] !== 32'h0000_0014) begin n_fail++; $display("FAIL err_sw_06_word1 got %h want 00000014", mem[1]); end
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h80, 32'h0);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_lb_80 got err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h80, 32'h55);
        n_tests++; if (er !== 1'b1 || nwr !== 0) begin n_fail++; $display("FAIL err_sb_80 got err=%b writes=%0d want 1/0", er, nwr); end
        do_req(1'b0, SZ_ILLEGAL, 1'b0, 32'h00, 32'h0);
        n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_size11 got err=%b rdata=%h want 1/0", er, rd); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0);
        n_tests++; if (er !== 1'b0 || rd !== 32'h14) begin n_fail++; $display("FAIL post_err_lw got err=%b rdata=%h want 0/14", er, rd); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = 32'h04; req_wdata = '0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h14 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d got valid=%b rdata=%h ready=%b want 1/00000014/0", i, rsp_valid, rsp_rdata, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stall_release_state got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_back_to_back();
        int ab;
        int wb;
        ab = accept_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = 32'h04; req_wdata = '0;
        repeat (9) tick();
        req_valid = 1'b0;
        n_tests++; if (accept_cnt - ab !== 3) begin n_fail++; $display("FAIL b2b_load_accepts got %0d want 3", accept_cnt - ab); end
        tick();
        ab = accept_cnt;
        wb = write_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE;
        req_addr = 32'h15; req_wdata = 32'h0000_00A5;
        repeat (8) tick();
        req_valid = 1'b0;
        n_tests++; if (accept_cnt - ab !== 2) begin n_fail++; $display("FAIL b2b_sb_accepts got %0d want 2", accept_cnt - ab); end
        n_tests++; if (write_cnt - wb !== 2) begin n_fail++; $display("FAIL b2b_sb_writes got %0d want 2", write_cnt - wb); end
        n_tests++; if (mem[5] !== 32'hCAFE_A50D) begin n_fail++; $display("FAIL b2b_sb_word5 got %h want cafea50d", mem[5]); end
        tick();
    endtask

    task automatic test_reset_merge();
        int wb;
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_HALF;
        req_unsigned = 1'b0; req_addr = 32'h1A; req_wdata = 32'h0000_BEEF;
        tick();
        req_valid = 1'b0;
        tick();
        n_tests++; if (dbg_state !== MERGE_WR) begin n_fail++; $display("FAIL rm_in_merge got %0d want MERGE_WR", dbg_state); end
        wb = write_cnt;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_tests++; if (write_cnt - wb !== 0) begin n_fail++; $display("FAIL rm_writes got %0d want 0", write_cnt - wb); end
        n_tests++; if (mem[6] !== 32'h5566_7788) begin n_fail++; $display("FAIL rm_word6 got %h want 55667788", mem[6]); end
        n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_outputs got ready=%b valid=%b err=%b rdata=%h wr=%b want 1/0/0/0/0", req_ready, rsp_valid, rsp_err, rsp_rdata, mem_write);
        end
        tick();
        n_tests++; if (mem[6] !== 32'h5566_7788) begin n_fail++; $display("FAIL rm_word6_after got %h want 55667788", mem[6]); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        write_cnt = 0; merge_wr_cnt = 0; accept_cnt = 0;
        for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        #1;
        mem[1] <= 32'h0000_0014;
        mem[2] <= 32'h1234_80FF;
        mem[3] <= 32'hAABB_CCDD;
        mem[4] <= 32'h0123_4567;
        mem[6] <= 32'h5566_7788;
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_merge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
